// File: rtl/ctrl_pipe_regs_if.sv
// Bundle between ID-stage control generation and the EX/MEM/WB control pipeline.
// The master drives the ID-side controls; the slave returns the registered stage fields.
interface ctrl_pipe_regs_if #(
    parameter int unsigned RD_W  = 5,
    parameter int unsigned CNT_W = 32
);
    logic              valid_i;
    logic [2:0]        EX_i;
    logic [2:0]        M_i;
    logic [1:0]        WB_i;
    logic [RD_W-1:0]   rd_i;
    logic              bubble_i;
    logic              flush_i;
    logic              hold_i;

    logic [2:0]        idex_EX_o;
    logic [2:0]        idex_M_o;
    logic [1:0]        idex_WB_o;
    logic [RD_W-1:0]   idex_rd_o;
    logic              idex_MemRead_o;
    logic [2:0]        exmem_M_o;
    logic [1:0]        exmem_WB_o;
    logic [RD_W-1:0]   exmem_rd_o;
    logic [1:0]        memwb_WB_o;
    logic [RD_W-1:0]   memwb_rd_o;
    logic              memwb_valid_o;
    logic [CNT_W-1:0]  retire_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output valid_i, EX_i, M_i, WB_i, rd_i, bubble_i, flush_i, hold_i,
        input  idex_EX_o, idex_M_o, idex_WB_o, idex_rd_o, idex_MemRead_o,
               exmem_M_o, exmem_WB_o, exmem_rd_o,
               memwb_WB_o, memwb_rd_o, memwb_valid_o,
               retire_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  valid_i, EX_i, M_i, WB_i, rd_i, bubble_i, flush_i, hold_i,
        output idex_EX_o, idex_M_o, idex_WB_o, idex_rd_o, idex_MemRead_o,
               exmem_M_o, exmem_WB_o, exmem_rd_o,
               memwb_WB_o, memwb_rd_o, memwb_valid_o,
               retire_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control pipeline registers with bubble/flush/hold
// handling plus retired-instruction and inserted-bubble counters.
module ctrl_pipe_regs #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned RD_W  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ctrl_pipe_regs_if.slave bus
);
    typedef struct packed {
        logic [2:0]      ex;
        logic [2:0]      m;
        logic [1:0]      wb;
        logic [RD_W-1:0] rd;
        logic            valid;
    } idex_t;

    typedef struct packed {
        logic [2:0]      m;
        logic [1:0]      wb;
        logic [RD_W-1:0] rd;
        logic            valid;
    } exmem_t;

    typedef struct packed {
        logic [1:0]      wb;
        logic [RD_W-1:0] rd;
        logic            valid;
    } memwb_t;

    idex_t            idex_q,  idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             squash;
    logic             count_bubble;

    // A squashed slot enters ID/EX as all-zero control so it can never write.
    always_comb begin
        squash       = bus.bubble_i | bus.flush_i | ~bus.valid_i;
        count_bubble = bus.valid_i & (bus.bubble_i | bus.flush_i);
    end

    always_comb begin
        idex_d       = idex_q;
        exmem_d      = exmem_q;
        memwb_d      = memwb_q;
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (!bus.hold_i) begin
            if (squash) begin
                idex_d = '0;
            end else begin
                idex_d.ex    = bus.EX_i;
                idex_d.m     = bus.M_i;
                idex_d.wb    = bus.WB_i;
                idex_d.rd    = bus.rd_i;
                idex_d.valid = 1'b1;
            end

            exmem_d.m     = idex_q.m;
            exmem_d.wb    = idex_q.wb;
            exmem_d.rd    = idex_q.rd;
            exmem_d.valid = idex_q.valid;

            memwb_d.wb    = exmem_q.wb;
            memwb_d.rd    = exmem_q.rd;
            memwb_d.valid = exmem_q.valid;

            if (memwb_q.valid) begin
                retire_cnt_d = retire_cnt_q + CNT_W'(1);
            end
            if (count_bubble) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.idex_EX_o      = idex_q.ex;
    assign bus.idex_M_o       = idex_q.m;
    assign bus.idex_WB_o      = idex_q.wb;
    assign bus.idex_rd_o      = idex_q.rd;
    assign bus.idex_MemRead_o = idex_q.m[1];
    assign bus.exmem_M_o      = exmem_q.m;
    assign bus.exmem_WB_o     = exmem_q.wb;
    assign bus.exmem_rd_o     = exmem_q.rd;
    assign bus.memwb_WB_o     = memwb_q.wb;
    assign bus.memwb_rd_o     = memwb_q.rd;
    assign bus.memwb_valid_o  = memwb_q.valid;
    assign bus.retire_cnt_o   = retire_cnt_q;
    assign bus.bubble_cnt_o   = bubble_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed plus randomized bench for ctrl_pipe_regs: a 32-bit-counter instance
// and a 4-bit-counter instance share stimulus and are checked against a record model.
module tb_ctrl_pipe_regs;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [2:0] ex_in = '0;
    logic [2:0] m_in = '0;
    logic [1:0] wb_in = '0;
    logic [4:0] rd_in = '0;
    logic       bubble = 1'b0;
    logic       flush = 1'b0;
    logic       hold = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe_regs_if #(.RD_W(5), .CNT_W(32)) bus_a ();
    ctrl_pipe_regs_if #(.RD_W(5), .CNT_W(4))  bus_b ();

    assign bus_a.valid_i  = valid;
    assign bus_a.EX_i     = ex_in;
    assign bus_a.M_i      = m_in;
    assign bus_a.WB_i     = wb_in;
    assign bus_a.rd_i     = rd_in;
    assign bus_a.bubble_i = bubble;
    assign bus_a.flush_i  = flush;
    assign bus_a.hold_i   = hold;
    assign bus_b.valid_i  = valid;
    assign bus_b.EX_i     = ex_in;
    assign bus_b.M_i      = m_in;
    assign bus_b.WB_i     = wb_in;
    assign bus_b.rd_i     = rd_in;
    assign bus_b.bubble_i = bubble;
    assign bus_b.flush_i  = flush;
    assign bus_b.hold_i   = hold;

    ctrl_pipe_regs #(.CNT_W(32), .RD_W(5)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    ctrl_pipe_regs #(.CNT_W(4),  .RD_W(5)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    // Reference: slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, each a whole instruction record.
    typedef struct {
        logic [2:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic [4:0] rd;
        logic       valid;
    } rec_t;

    rec_t        slot [3];
    int unsigned retired;
    int unsigned bubbles;

    function automatic rec_t empty_rec();
        rec_t r;
        r.ex = 3'd0; r.m = 3'd0; r.wb = 2'd0; r.rd = 5'd0; r.valid = 1'b0;
        return r;
    endfunction

    task automatic model_step();
        rec_t incoming;
        if (rst) begin
            for (int i = 0; i < 3; i++) slot[i] = empty_rec();
            retired = 0;
            bubbles = 0;
        end else if (!hold) begin
            if (slot[2].valid) retired = retired + 1;
            if (valid && (bubble || flush)) bubbles = bubbles + 1;
            incoming = empty_rec();
            if (valid && !bubble && !flush) begin
                incoming.ex = ex_in; incoming.m = m_in; incoming.wb = wb_in;
                incoming.rd = rd_in; incoming.valid = 1'b1;
            end
            slot[2] = slot[1];
            slot[1] = slot[0];
            slot[0] = incoming;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("idex_ex",    32'(bus_a.idex_EX_o),      32'(slot[0].ex));
        chk("idex_m",     32'(bus_a.idex_M_o),       32'(slot[0].m));
        chk("idex_wb",    32'(bus_a.idex_WB_o),      32'(slot[0].wb));
        chk("idex_rd",    32'(bus_a.idex_rd_o),      32'(slot[0].rd));
        chk("idex_mrd",   32'(bus_a.idex_MemRead_o), 32'(slot[0].m[1]));
        chk("exmem_m",    32'(bus_a.exmem_M_o),      32'(slot[1].m));
        chk("exmem_wb",   32'(bus_a.exmem_WB_o),     32'(slot[1].wb));
        chk("exmem_rd",   32'(bus_a.exmem_rd_o),     32'(slot[1].rd));
        chk("memwb_wb",   32'(bus_a.memwb_WB_o),     32'(slot[2].wb));
        chk("memwb_rd",   32'(bus_a.memwb_rd_o),     32'(slot[2].rd));
        chk("memwb_v",    32'(bus_a.memwb_valid_o),  32'(slot[2].valid));
        chk("retire",     bus_a.retire_cnt_o,        retired);
        chk("bubble",     bus_a.bubble_cnt_o,        bubbles);
        chk("retire4",    32'(bus_b.retire_cnt_o),   retired % 16);
        chk("bubble4",    32'(bus_b.bubble_cnt_o),   bubbles % 16);
        chk("memwb_v4",   32'(bus_b.memwb_valid_o),  32'(slot[2].valid));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic v, input logic [2:0] e, input logic [2:0] m,
                          input logic [1:0] w, input logic [4:0] r);
        valid = v; ex_in = e; m_in = m; wb_in = w; rd_in = r;
    endtask

    task automatic rand_fields();
        ex_in = 3'($urandom); m_in = 3'($urandom); wb_in = 2'($urandom); rd_in = 5'($urandom);
    endtask

    int unsigned prev_bub;

    initial begin
        for (int i = 0; i < 3; i++) slot[i] = empty_rec();
        retired = 0;
        bubbles = 0;

        // Reset state
        rst = 1'b1;
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single instruction walking through all three stages
        set_in(1'b1, 3'b101, 3'b010, 2'b11, 5'd7);
        cycle();
        chk("t1_idex_ex", 32'(bus_a.idex_EX_o), 32'h5);
        chk("t1_idex_rd", 32'(bus_a.idex_rd_o), 32'd7);
        set_in(1'b0, 3'b000, 3'b000, 2'b00, 5'd0);
        cycle();
        chk("t1_exmem_m", 32'(bus_a.exmem_M_o), 32'h2);
        cycle();
        chk("t1_memwb_wb", 32'(bus_a.memwb_WB_o), 32'h3);
        chk("t1_memwb_v", 32'(bus_a.memwb_valid_o), 32'd1);
        cycle();
        chk("t1_retire", bus_a.retire_cnt_o, 32'd1);

        // Load-use bubble
        set_in(1'b1, 3'b111, 3'b010, 2'b11, 5'd9);
        bubble = 1'b1;
        cycle();
        chk("t2_idex_m", 32'(bus_a.idex_M_o), 32'd0);
        chk("t2_idex_mrd", 32'(bus_a.idex_MemRead_o), 32'd0);
        chk("t2_bubble", bus_a.bubble_cnt_o, 32'd1);
        bubble = 1'b0;
        valid = 1'b0;
        cycle();
        cycle();
        chk("t2_memwb_v", 32'(bus_a.memwb_valid_o), 32'd0);
        chk("t2_retire", bus_a.retire_cnt_o, 32'd1);

        // Hold with changing inputs and a flush seen only during hold
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            rand_fields();
            cycle();
        end
        hold = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            valid = 1'($urandom);
            bubble = 1'($urandom);
            cycle();
        end
        hold = 1'b0;
        flush = 1'b0;
        bubble = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            rand_fields();
            cycle();
        end

        // Flush and bubble on the same edge count once
        prev_bub = bubbles;
        valid = 1'b1; bubble = 1'b1; flush = 1'b1;
        cycle();
        chk("t4_bubble", bus_a.bubble_cnt_o, prev_bub + 1);
        chk("t4_idex_rd", 32'(bus_a.idex_rd_o), 32'd0);
        bubble = 1'b0; flush = 1'b0;

        // Reset with instructions in flight
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'b011, 3'b110, 2'b10, 5'(i + 20));
            cycle();
        end
        rst = 1'b1;
        cycle();
        chk("t5_memwb_v", 32'(bus_a.memwb_valid_o), 32'd0);
        chk("t5_exmem_rd", 32'(bus_a.exmem_rd_o), 32'd0);
        chk("t5_retire", bus_a.retire_cnt_o, 32'd0);
        chk("t5_bubble", bus_a.bubble_cnt_o, 32'd0);
        rst = 1'b0;

        // 17 back-to-back instructions: 4-bit retire counter wraps 15 -> 0 -> 1
        for (int k = 1; k <= 22; k++) begin
            if (k <= 17) begin
                valid = 1'b1;
                rand_fields();
            end else begin
                valid = 1'b0;
            end
            cycle();
            if (k == 18) chk("t6_wrap15", 32'(bus_b.retire_cnt_o), 32'd15);
            if (k == 19) chk("t6_wrap0",  32'(bus_b.retire_cnt_o), 32'd0);
            if (k == 20) chk("t6_wrap1",  32'(bus_b.retire_cnt_o), 32'd1);
        end

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rand_fields();
            valid  = ($urandom_range(0, 3) != 0);
            bubble = ($urandom_range(0, 5) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            hold   = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0; hold = 1'b0; bubble = 1'b0; flush = 1'b0; valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
